// File: rtl/lights_decoder_pkg.sv
// lights_decoder_pkg: shared FSM states, colour codes and sequence successor
package lights_decoder_pkg;
  typedef enum logic [1:0] {HUNT, SETTLE, LOCKED} state_t;
  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;
  // Successor in the 1..6 ring; BLACK and WHITE return themselves, meaning "no successor".
  function automatic logic [2:0] seq_next(input logic [2:0] c);
    return (c == BLACK || c == WHITE) ? c : (c == YELLOW) ? BLUE : c + 3'd1;
  endfunction
endpackage

// File: rtl/lights_decoder_rgb_classify.sv
// rgb_classify: maps a 24-bit RGB word to a 3-bit code when every byte is 00 or FF
module rgb_classify (
  input  logic [23:0] i_rgb,
  output logic [2:0]  o_code,
  output logic        o_enc
);
  // Each byte must be all-zeros or all-ones; the code takes the all-ones bits.
  always_comb begin
    o_code = {&i_rgb[23:16], &i_rgb[15:8], &i_rgb[7:0]};
    o_enc  = (~|i_rgb[23:16] | &i_rgb[23:16]) &
             (~|i_rgb[15:8]  | &i_rgb[15:8])  &
             (~|i_rgb[7:0]   | &i_rgb[7:0]);
  end
endmodule

// File: rtl/lights_decoder.sv
// lights_decoder: debounces RGB samples into colour codes and flags sequence steps
module lights_decoder
  import lights_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [23:0] light,
  output logic [2:0]  colour,
  output logic        locked,
  output logic        white,
  output logic        step,
  output logic        error,
  output logic [7:0]  step_count
);
  localparam logic [3:0] LP_N = 4'(STABLE_CYCLES);
  logic        r_valid;
  logic [23:0] r_light;
  state_t      r_state, w_state_n;
  logic [2:0]  r_cand, w_cand_n, r_colour, w_colour_n;
  logic [3:0]  r_count, w_count_n;
  logic        r_locked, w_locked_n, r_step, w_step_n, r_error, w_error_n;
  logic [7:0]  r_step_count;
  logic [2:0]  w_code;
  logic        w_enc;
  rgb_classify u_classify (
    .i_rgb  (r_light),
    .o_code (w_code),
    .o_enc  (w_enc)
  );
  // Input stage: all classification works on this registered copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_light <= '0;
    end else begin
      r_valid <= valid;
      r_light <= light;
    end
  end
  // State, candidate, outputs and step counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= HUNT;
      r_cand       <= BLACK;
      r_count      <= '0;
      r_colour     <= BLACK;
      r_locked     <= 1'b0;
      r_step       <= 1'b0;
      r_error      <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cand       <= w_cand_n;
      r_count      <= w_count_n;
      r_colour     <= w_colour_n;
      r_locked     <= w_locked_n;
      r_step       <= w_step_n;
      r_error      <= w_error_n;
      r_step_count <= r_step_count + {7'd0, w_step_n};
    end
  end
  // Next-state logic; idle cycles (no registered valid) hold everything and raise no pulse.
  always_comb begin
    w_state_n  = r_state;
    w_cand_n   = r_cand;
    w_count_n  = r_count;
    w_colour_n = r_colour;
    w_locked_n = r_locked;
    w_step_n   = 1'b0;
    w_error_n  = 1'b0;
    if (r_valid) begin
      case (r_state)
        HUNT: begin
          if (w_enc) begin
            w_state_n = SETTLE;
            w_cand_n  = w_code;
            w_count_n = 4'd1;
          end else begin
            w_error_n = 1'b1;
          end
        end
        SETTLE: begin
          if (!w_enc) begin
            w_error_n  = 1'b1;
            w_locked_n = 1'b0;
            w_state_n  = HUNT;
          end else if (w_code == r_cand) begin
            w_count_n = r_count + 4'd1;
            if (r_count + 4'd1 == LP_N) begin
              w_state_n  = LOCKED;
              w_colour_n = r_cand;
              w_locked_n = 1'b1;
              w_step_n   = r_locked && seq_next(r_colour) != r_colour && seq_next(r_colour) == r_cand;
            end
          end else begin
            w_cand_n  = w_code;
            w_count_n = 4'd1;
          end
        end
        LOCKED: begin
          if (!w_enc) begin
            w_error_n  = 1'b1;
            w_locked_n = 1'b0;
            w_state_n  = HUNT;
          end else if (w_code != r_colour) begin
            w_state_n = SETTLE;
            w_cand_n  = w_code;
            w_count_n = 4'd1;
          end
        end
        default: w_state_n = HUNT;
      endcase
    end
  end
  assign colour     = r_colour;
  assign locked     = r_locked;
  assign white      = r_locked && r_colour == WHITE;
  assign step       = r_step;
  assign error      = r_error;
  assign step_count = r_step_count;
endmodule

// File: tb/tb_lights_decoder.sv
// tb_lights_decoder: directed scoreboard bench for lights_decoder
module tb_lights_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] light = '0;
  logic [2:0]  colour;
  logic        locked, white, step, error;
  logic [7:0]  step_count;
  typedef struct {
    int          due;
    string       tag;
    logic [14:0] want;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_cnt = '0;
  int          cur, nxt;
  lights_decoder #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .light      (light),
    .colour     (colour),
    .locked     (locked),
    .white      (white),
    .step       (step),
    .error      (error),
    .step_count (step_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [23:0] rgb(input int c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
  task automatic check();
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_vec++;
      assert (e.due == cyc && {colour, locked, white, step, error, step_count} === e.want) else begin
        n_bad++;
        $error("FAIL %s: got colour=%0d locked=%b white=%b step=%b error=%b step_count=%0d at cycle %0d, want colour=%0d locked=%b white=%b step=%b error=%b step_count=%0d at cycle %0d",
               e.tag, colour, locked, white, step, error, step_count, cyc,
               e.want[14:12], e.want[11], e.want[10], e.want[9], e.want[8], e.want[7:0], e.due);
      end
    end
  endtask
  task automatic tick(input logic v, input logic [23:0] l, input logic r = 1'b1);
    @(negedge clk);
    check();
    rst   = r;
    valid = v;
    light = l;
  endtask
  task automatic run(input logic [23:0] l, input int n);
    repeat (n) tick(1'b1, l);
  endtask
  task automatic push_exp(input string tag, input logic [2:0] col, input logic lk,
                          input logic st, input logic er, input int off = 2);
    exp_t x;
    x.due  = cyc + off;
    x.tag  = tag;
    x.want = {col, lk, lk && col == 3'd7, st, er, exp_cnt};
    q.push_back(x);
  endtask
  task automatic do_reset(input string tag);
    exp_cnt = '0;
    tick(1'b1, 24'hFF0000, 1'b0);
    push_exp(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1);
  endtask
  initial begin
    do_reset("reset");
    run(24'hFF0000, 3);  push_exp("red_3", 3'd0, 0, 0, 0);
    run(24'hFF0000, 1);  push_exp("red_lock", 3'd4, 1, 0, 0);
    tick(1'b0, '0);      push_exp("red_nostep", 3'd4, 1, 0, 0);
    run(24'h0000FF, 4);  push_exp("blue_lock", 3'd1, 1, 0, 0);
    run(24'h00FF00, 4);  exp_cnt = 8'd1; push_exp("step_1_2", 3'd2, 1, 1, 0);
    tick(1'b0, '0);      push_exp("step_once", 3'd2, 1, 0, 0);
    run(24'hFFFF00, 4);  push_exp("yellow_lock", 3'd6, 1, 0, 0);
    run(24'h0000FF, 4);  exp_cnt = 8'd2; push_exp("wrap_6_1", 3'd1, 1, 1, 0);
    run(24'h00FFFF, 4);  push_exp("cyan_lock", 3'd3, 1, 0, 0);
    run(24'hFF00FF, 4);  push_exp("skip_3_5", 3'd5, 1, 0, 0);
    run(24'hFFFFFF, 4);  push_exp("white_lock", 3'd7, 1, 0, 0);
    run(24'hFFFFFF, 1);  push_exp("white_hold", 3'd7, 1, 0, 0);
    run(24'h00FF00, 4);  push_exp("from_white", 3'd2, 1, 0, 0);
    run(24'h7F0000, 1);  push_exp("bad_error", 3'd2, 0, 0, 1);
    tick(1'b0, '0);      push_exp("error_once", 3'd2, 0, 0, 0);
    run(24'h00FFFF, 3);  push_exp("hunt_3", 3'd2, 0, 0, 0);
    run(24'h00FFFF, 1);  push_exp("relock_nostep", 3'd3, 1, 0, 0);
    run(24'hFF0000, 3);  push_exp("settle_3", 3'd3, 1, 0, 0);
    repeat (5) tick(1'b0, 24'h7F7F7F);
    run(24'hFF0000, 1);  exp_cnt = 8'd3; push_exp("gap_accept", 3'd4, 1, 1, 0);
    run(24'h00FF00, 2);
    do_reset("mid_settle_rst");
    run(24'h00FF00, 3);  push_exp("post_rst_3", 3'd0, 0, 0, 0);
    run(24'h00FF00, 1);  push_exp("post_rst_lock", 3'd2, 1, 0, 0);
    cur = 2;
    for (int i = 0; i < 256; i++) begin
      nxt = cur % 6 + 1;
      run(rgb(nxt), 4);
      exp_cnt = exp_cnt + 8'd1;
      push_exp("seq_step", nxt[2:0], 1, 1, 0);
      cur = nxt;
    end
    tick(1'b0, '0);      push_exp("wrap_zero", cur[2:0], 1, 0, 0);
    for (int i = 0; i < 6 && q.size() > 0; i++) tick(1'b0, '0);
    assert (q.size() == 0) else begin
      n_bad++;
      $error("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
